// File: rtl/hex_word_serializer.sv
// hex_word_serializer
//   Accepts a binary word over a valid/ready handshake and streams it as
//   uppercase ASCII hex characters, most-significant nibble first, one character
//   per output handshake. It can optionally append a separator character after
//   the last digit.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block can take a word this cycle
//   in_data    word to convert (WORD_WIDTH bits)
//   out_valid  out_char is valid
//   out_ready  sink accepts out_char this cycle
//   out_char   ASCII character (0 when out_valid is low)
//   out_last   final character of the current word
//   busy       word in progress (same as out_valid)
module hex_word_serializer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter bit          APPEND_SEP = 1'b1,
  parameter logic [7:0]  SEP_CHAR   = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned NIB = WORD_WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StEmit, StSep} state_e;

  state_e                state;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         cnt;
  logic [3:0]            top_nib;
  logic                  accept;
  logic                  xfer;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 'A' - 10 = 8'h37
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign top_nib = shift_reg[WORD_WIDTH-1 -: 4];

  // Outputs decode only registered state, so they hold steady while stalled.
  always_comb begin
    out_valid = (state != StIdle);
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state)
      StEmit: begin
        out_char = hex_ascii(top_nib);
        out_last = (cnt == '0) && !APPEND_SEP;
      end
      StSep: begin
        out_char = SEP_CHAR;
        out_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = out_valid;
  // Combinational term from out_ready allows a new word to load on the same
  // edge that the last character leaves, giving back-to-back words with no bubble.
  assign in_ready = (state == StIdle) | (out_valid & out_ready & out_last);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            shift_reg <= in_data;
            cnt       <= CNT_INIT;
            state     <= StEmit;
          end
        end
        StEmit: begin
          if (xfer) begin
            if (cnt != '0) begin
              shift_reg <= shift_reg << 4;
              cnt       <= cnt - CW'(1);
            end else if (APPEND_SEP) begin
              state <= StSep;
            end else if (accept) begin
              shift_reg <= in_data;
              cnt       <= CNT_INIT;
            end else begin
              state <= StIdle;
            end
          end
        end
        StSep: begin
          if (xfer) begin
            if (accept) begin
              shift_reg <= in_data;
              cnt       <= CNT_INIT;
              state     <= StEmit;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_serializer.sv
// Testbench for hex_word_serializer: a default 32-bit instance with a space
// separator, and an 8-bit instance without a separator.
module tb_hex_word_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;
  logic        busy;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_char;
  logic        b_out_last;
  logic        b_busy;

  hex_word_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last),
    .busy      (busy)
  );

  hex_word_serializer #(
    .WORD_WIDTH (8),
    .APPEND_SEP (1'b0),
    .SEP_CHAR   (8'h20)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_char  (b_out_char),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int rdy_mode = 0;  // 0 = always ready, 1 = random, 2 = pattern 1,0,0
  int ph = 0;

  logic [7:0] rx_char[$];
  logic       rx_last[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];

  string hexdig = "0123456789ABCDEF";

  typedef struct {
    logic [31:0] data;
    string       exp;
  } vec_t;
  vec_t tbl[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink ready driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  // Monitor: records transfers and checks handshake invariants and stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char  = 8'h00;
  logic       prev_last  = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("busy_eq_valid", 32'(busy), 32'(out_valid));
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || (out_ready && out_last)));
      if (!out_valid) chk("idle_outputs", {23'd0, out_last, out_char}, 32'd0);
      if (prev_stall && out_valid)
        chk("stall_stable", {23'd0, out_last, out_char}, {23'd0, prev_last, prev_char});
      if (out_valid && out_ready) begin
        rx_char.push_back(out_char);
        rx_last.push_back(out_last);
        rx_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
      prev_last  = out_last;
    end
  end

  task automatic clear_rx();
    rx_char.delete();
    rx_last.delete();
    rx_cyc.delete();
    exp_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 for word %h", d);
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 3000 && rx_char.size() < n; k++) @(negedge clk);
    if (rx_char.size() < n) begin
      vectors++;
      errors++;
      $display("FAIL rx_timeout: got %0d chars, expected %0d", rx_char.size(), n);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Reference model: digits straight from the word's value, MS nibble first.
  task automatic push_model(input logic [31:0] w);
    int d;
    for (int i = 7; i >= 0; i--) begin
      d = int'((w >> (4 * i)) & 32'hF);
      exp_q.push_back(hexdig[d]);
    end
    exp_q.push_back(8'h20);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_count"}, 32'(rx_char.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_char.size(); i++) begin
      chk({name, "_char"}, 32'(rx_char[i]), 32'(exp_q[i]));
      chk({name, "_last"}, 32'(rx_last[i]), 32'((i % 9) == 8));
    end
  endtask

  initial begin
    logic [31:0] w;
    tbl[0] = '{data: 32'h1234ABCD, exp: "1234ABCD "};
    tbl[1] = '{data: 32'h00000000, exp: "00000000 "};
    tbl[2] = '{data: 32'hFFFFFFFF, exp: "FFFFFFFF "};
    tbl[3] = '{data: 32'h9A0B1C2D, exp: "9A0B1C2D "};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    b_in_valid = 1'b0;
    b_in_data = '0;
    b_out_ready = 1'b1;
    #2;
    chk("reset_outputs", {22'd0, busy, out_valid, out_last, out_char}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Table-driven words with out_ready held high.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    foreach (tbl[t]) begin
      clear_rx();
      push_str(tbl[t].exp);
      send(tbl[t].data);
      wait_rx(9);
      check_stream("table");
      if (rx_cyc.size() > 0) chk("first_latency", 32'(rx_cyc[0]), 32'(acc_cyc));
      for (int i = 1; i < rx_cyc.size(); i++)
        chk("table_contig", 32'(rx_cyc[i]), 32'(rx_cyc[0] + i));
    end

    // Backpressure with ready pattern 1,0,0.
    clear_rx();
    ph = 0;
    rdy_mode = 2;
    push_str("0000000F ");
    send(32'h0000000F);
    wait_rx(9);
    check_stream("backpressure");

    // Back-to-back words.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    clear_rx();
    push_model(32'hDEADBEEF);
    push_model(32'h00C0FFEE);
    send(32'hDEADBEEF);
    send(32'h00C0FFEE);
    wait_rx(18);
    check_stream("b2b");
    for (int i = 1; i < rx_cyc.size(); i++)
      chk("b2b_contig", 32'(rx_cyc[i]), 32'(rx_cyc[0] + i));

    // Reset mid-word.
    clear_rx();
    send(32'h89ABCDEF);
    for (int k = 0; k < 50 && rx_char.size() < 3; k++) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_outputs", {22'd0, busy, out_valid, out_last, out_char}, 32'd0);
    if (rx_char.size() >= 3)
      chk("midrst_prefix", {8'd0, rx_char[0], rx_char[1], rx_char[2]}, 32'h00383941);
    else
      chk("midrst_prefix_count", 32'(rx_char.size()), 32'd3);
    clear_rx();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    push_str("00000001 ");
    send(32'h00000001);
    wait_rx(9);
    check_stream("after_reset");

    // in_valid pulsed while busy is ignored.
    clear_rx();
    push_str("01234567 ");
    send(32'h01234567);
    for (int k = 0; k < 50 && rx_char.size() < 3; k++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_rx(9);
    repeat (10) @(posedge clk);
    #1;
    check_stream("ignored");
    chk("ignored_idle", 32'(out_valid), 32'd0);

    // Randomised words and sink stalls against the reference model.
    clear_rx();
    rdy_mode = 1;
    for (int n = 0; n < 15; n++) begin
      w = $urandom;
      push_model(w);
      send(w);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 12)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_rx(135);
    check_stream("random");
    rdy_mode = 0;

    // 8-bit instance without separator.
    @(negedge clk);
    chk("nosep_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b1;
    b_in_data  = 8'hF0;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("nosep_c0", {22'd0, b_out_valid, b_out_last, b_out_char}, {22'd0, 2'b10, 8'h46});
    @(negedge clk);
    chk("nosep_c1", {22'd0, b_out_valid, b_out_last, b_out_char}, {22'd0, 2'b11, 8'h30});
    chk("nosep_c1_ready", 32'(b_in_ready), 32'd1);
    @(negedge clk);
    chk("nosep_idle", {21'd0, b_in_ready, b_out_valid, b_out_last, b_out_char},
        {21'd0, 3'b100, 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
